// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// One latched transaction at a time, round-robin on ties, timeout abort with error.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic              ownerData;
  logic              lastOwnerData;
  logic [ADDR_W-1:0] addrQ;
  logic              weQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdataQ;
  logic [CNT_W-1:0]  cnt;
  logic              memReqQ;
  logic              ifDoneQ;
  logic              dmDoneQ;
  logic              errQ;
  logic              busyQ;
  logic              grantData;

  // Data wins only when fetch is absent or fetch was served last.
  assign grantData = dm_req & (~if_req | ~lastOwnerData);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ownerData     <= 1'b0;
      lastOwnerData <= 1'b1;
      addrQ         <= '0;
      weQ           <= 1'b0;
      wdataQ        <= '0;
      rdataQ        <= '0;
      cnt           <= '0;
      memReqQ       <= 1'b0;
      ifDoneQ       <= 1'b0;
      dmDoneQ       <= 1'b0;
      errQ          <= 1'b0;
      busyQ         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ifDoneQ <= 1'b0;
          dmDoneQ <= 1'b0;
          if (if_req || dm_req) begin
            state         <= ACCESS;
            memReqQ       <= 1'b1;
            busyQ         <= 1'b1;
            ownerData     <= grantData;
            lastOwnerData <= grantData;
            addrQ         <= grantData ? dm_addr : if_addr;
            weQ           <= grantData & dm_we;
            wdataQ        <= grantData ? dm_wdata : '0;
            cnt           <= '0;
          end
        end
        ACCESS: begin
          if (mem_ready || cnt == CNT_LAST) begin
            // Stores and aborted accesses both return zero data.
            rdataQ  <= (mem_ready && !weQ) ? mem_rdata : '0;
            errQ    <= ~mem_ready;
            state   <= RESP;
            memReqQ <= 1'b0;
            ifDoneQ <= ~ownerData;
            dmDoneQ <= ownerData;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ifDoneQ <= 1'b0;
          dmDoneQ <= 1'b0;
          busyQ   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          memReqQ <= 1'b0;
          ifDoneQ <= 1'b0;
          dmDoneQ <= 1'b0;
          busyQ   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = memReqQ;
  assign mem_we    = weQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign if_rdata  = rdataQ[31:0];
  assign dm_rdata  = rdataQ;
  assign if_done   = ifDoneQ;
  assign dm_done   = dmDoneQ;
  assign err       = errQ;
  assign busy      = busyQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus hand-written
// sequences for wait states, timeout, async reset and request-input changes.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  typedef struct {
    logic        ifReq;
    logic [63:0] ifAddr;
    logic        dmReq;
    logic        dmWe;
    logic [63:0] dmAddr;
    logic [63:0] dmWdata;
    logic [63:0] memRdata;
    logic        memReady;
    logic        eMemReq;
    logic        eMemWe;
    logic [63:0] eMemAddr;
    logic        eIfDone;
    logic        eDmDone;
    logic        eBusy;
    logic        eErr;
    logic [63:0] eRdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic ir, input logic [63:0] ia, input logic dr,
                                 input logic dw, input logic [63:0] da, input logic [63:0] dwd,
                                 input logic [63:0] mrd, input logic mry,
                                 input logic emr, input logic emw, input logic [63:0] ema,
                                 input logic eid, input logic edd, input logic eb,
                                 input logic ee, input logic [63:0] erd);
    vec_t v;
    v.ifReq = ir;  v.ifAddr = ia;  v.dmReq = dr;  v.dmWe = dw;  v.dmAddr = da;
    v.dmWdata = dwd;  v.memRdata = mrd;  v.memReady = mry;
    v.eMemReq = emr;  v.eMemWe = emw;  v.eMemAddr = ema;  v.eIfDone = eid;
    v.eDmDone = edd;  v.eBusy = eb;  v.eErr = ee;  v.eRdata = erd;
    vecs.push_back(v);
  endfunction

  task automatic idleInputs();
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    int reqCycles;
    int doneAt;

    r = 64'hCAFEF00D_11223344;
    // Both requesters held high from reset: fetch, data, fetch, data.
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  1, 0, 64'h80,  0, 0, 1, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 64'h80,  1, 0, 1, 0, 64'h11223344);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 0,       0, 0, 0, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  1, 0, 64'h180, 0, 0, 1, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 64'h180, 0, 1, 1, 0, r);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 0,       0, 0, 0, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  1, 0, 64'h80,  0, 0, 1, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 64'h80,  1, 0, 1, 0, 64'h11223344);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 0,       0, 0, 0, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  1, 0, 64'h180, 0, 0, 1, 0, 0);
    addVec(1, 64'h80, 1, 0, 64'h180, 0, r, 1,  0, 0, 64'h180, 0, 1, 1, 0, r);
    addVec(0, 0,      0, 0, 0,       0, r, 1,  0, 0, 0,       0, 0, 0, 0, 0);
    // Lone fetch from 0x40 with memory always ready.
    addVec(1, 64'h40, 0, 0, 0, 0, 64'hFFFF0000_00A00093, 1,  1, 0, 64'h40, 0, 0, 1, 0, 0);
    addVec(1, 64'h40, 0, 0, 0, 0, 64'hFFFF0000_00A00093, 1,  0, 0, 64'h40, 1, 0, 1, 0, 64'h00A00093);
    addVec(0, 0,      0, 0, 0, 0, 0,                     1,  0, 0, 0,      0, 0, 0, 0, 0);

    idleInputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst mem_req", 64'(mem_req), 0);
    chk("rst busy", 64'(busy), 0);
    chk("rst dones", 64'({if_done, dm_done}), 0);
    chk("rst err", 64'(err), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    #3 reset = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].ifReq;   if_addr = vecs[i].ifAddr;
      dm_req = vecs[i].dmReq;   dm_we = vecs[i].dmWe;
      dm_addr = vecs[i].dmAddr; dm_wdata = vecs[i].dmWdata;
      mem_rdata = vecs[i].memRdata; mem_ready = vecs[i].memReady;
      tick();
      chk($sformatf("v%0d mem_req", i), 64'(mem_req), 64'(vecs[i].eMemReq));
      chk($sformatf("v%0d if_done", i), 64'(if_done), 64'(vecs[i].eIfDone));
      chk($sformatf("v%0d dm_done", i), 64'(dm_done), 64'(vecs[i].eDmDone));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].eBusy));
      if (vecs[i].eMemReq) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].eMemAddr);
        chk($sformatf("v%0d mem_we", i), 64'(mem_we), 64'(vecs[i].eMemWe));
      end
      if (vecs[i].eIfDone) begin
        chk($sformatf("v%0d if_rdata", i), 64'(if_rdata), vecs[i].eRdata);
        chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].eErr));
      end
      if (vecs[i].eDmDone) begin
        chk($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].eRdata);
        chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].eErr));
      end
    end

    // Store with three wait states: write controls held four cycles.
    idleInputs();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h100; dm_wdata = 64'hDEADBEEF;
    mem_rdata = 64'h5555_AAAA_5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("st c%0d mem_req", c), 64'(mem_req), 1);
      chk($sformatf("st c%0d mem_we", c), 64'(mem_we), 1);
      chk($sformatf("st c%0d mem_wdata", c), mem_wdata, 64'hDEADBEEF);
      chk($sformatf("st c%0d mem_addr", c), mem_addr, 64'h100);
      chk($sformatf("st c%0d dm_done", c), 64'(dm_done), 0);
    end
    mem_ready = 1'b1;
    tick();
    chk("st dm_done", 64'(dm_done), 1);
    chk("st dm_rdata", dm_rdata, 0);
    chk("st err", 64'(err), 0);
    chk("st mem_req off", 64'(mem_req), 0);
    dm_req = 1'b0;
    tick();
    chk("st done pulse", 64'(dm_done), 0);

    // Load with memory never ready: abort after TIMEOUT cycles.
    idleInputs();
    dm_req = 1'b1; dm_addr = 64'h200; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    reqCycles = 0;
    doneAt = -1;
    for (int c = 1; c <= 40 && doneAt < 0; c++) begin
      tick();
      if (mem_req) reqCycles++;
      if (dm_done) doneAt = c;
      if (if_done) chk("to stray if_done", 64'(if_done), 0);
    end
    chk("to mem_req cycles", 64'(reqCycles), 16);
    chk("to done cycle", 64'(doneAt), 17);
    chk("to err", 64'(err), 1);
    chk("to dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    tick();
    dm_req = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    chk("to next dm_done", 64'(dm_done), 1);
    chk("to next err", 64'(err), 0);
    chk("to next dm_rdata", dm_rdata, 64'h1234_5678_9ABC_DEF0);
    dm_req = 1'b0;
    tick();

    // Async reset during the first access cycle of a fetch.
    idleInputs();
    if_req = 1'b1; if_addr = 64'h44; mem_rdata = 64'h0000_0000_0040_0113;
    tick();
    chk("ar mem_req before", 64'(mem_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar mem_req drop", 64'(mem_req), 0);
    chk("ar busy drop", 64'(busy), 0);
    tick();
    chk("ar no if_done", 64'(if_done), 0);
    #3 reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("ar reissue mem_req", 64'(mem_req), 1);
    chk("ar reissue addr", mem_addr, 64'h44);
    tick();
    chk("ar reissue if_done", 64'(if_done), 1);
    chk("ar reissue if_rdata", 64'(if_rdata), 64'h00400113);
    chk("ar reissue err", 64'(err), 0);
    if_req = 1'b0;
    tick();

    // Request address changing mid-access must not disturb the latched one.
    idleInputs();
    dm_req = 1'b1; dm_addr = 64'h300; mem_rdata = 64'h77;
    tick();
    chk("ac addr first", mem_addr, 64'h300);
    dm_addr = 64'h308;
    tick();
    chk("ac addr held", mem_addr, 64'h300);
    mem_ready = 1'b1;
    tick();
    chk("ac dm_done", 64'(dm_done), 1);
    chk("ac addr at done", mem_addr, 64'h300);
    chk("ac dm_rdata", dm_rdata, 64'h77);
    dm_req = 1'b0;
    tick();
    chk("ac idle", 64'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
